// File: rtl/mem_ctrl_param.sv
// mem_ctrl_param: parametrised single-port RAM behind valid/ready request and
// response channels, with programmable wait states and write-first/read-first
// selection for the write echo.
//
// Optional feature (macro MEM_CTRL_PARITY_EN): each word stores an even-parity
// bit alongside the data; adds input inj_perr and output rsp_perr.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake
//   req_we/addr/wdata       request payload (1 = write)
//   rsp_valid/rsp_ready     response handshake
//   rsp_rdata               read data, or write echo (new/old per WRITE_FIRST)
//   busy                    high whenever the controller is not idle
//   inj_perr, rsp_perr      parity injection / parity error (parity build only)
module mem_ctrl_param #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 0,
  parameter bit          WRITE_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
`ifdef MEM_CTRL_PARITY_EN
  input  logic              inj_perr,
  output logic              rsp_perr,
`endif
  output logic              busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 4;
`ifdef MEM_CTRL_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                req_ready_q, req_ready_d;
  logic                busy_q, busy_d;
`ifdef MEM_CTRL_PARITY_EN
  logic                inj_q, inj_d;
  logic                perr_q, perr_d;
`endif

  // Storage array; deliberately not reset so contents survive rst_n.
  logic [MEM_W-1:0]    mem_q [DEPTH];
  logic [MEM_W-1:0]    rd_word;
  logic [MEM_W-1:0]    wr_word;
  logic                mem_we;

  assign rd_word = mem_q[addr_q];
  assign mem_we  = (state_q == S_ACCESS) && we_q;

`ifdef MEM_CTRL_PARITY_EN
  // Even parity bit over the data, optionally inverted to model a corrupt word.
  assign wr_word = {(^wdata_q) ^ inj_q, wdata_q};
`else
  assign wr_word = wdata_q;
`endif

  // Array write on the closing edge of ACCESS.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr_q] <= wr_word;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = rsp_valid_q;
`ifdef MEM_CTRL_PARITY_EN
    inj_d       = inj_q;
    perr_d      = perr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
`ifdef MEM_CTRL_PARITY_EN
          inj_d   = inj_perr;
`endif
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACCESS: begin
        // Read-first echo takes the pre-write word from the same cycle.
        if (we_q && WRITE_FIRST) begin
          rdata_d = wdata_q;
        end else begin
          rdata_d = rd_word[DATA_W-1:0];
        end
`ifdef MEM_CTRL_PARITY_EN
        perr_d = !we_q && (rd_word[DATA_W] != (^rd_word[DATA_W-1:0]));
`endif
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
`ifdef MEM_CTRL_PARITY_EN
      inj_q       <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
`ifdef MEM_CTRL_PARITY_EN
      inj_q       <= inj_d;
      perr_q      <= perr_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign busy      = busy_q;
`ifdef MEM_CTRL_PARITY_EN
  assign rsp_perr  = perr_q;
`endif

endmodule
